decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter IW, 16, instruction width in bits; the only supported value is 16.
REQ-002 Parameter OPC_ILLEGAL_MIN, 4'd12, lowest illegal opcode; opcodes at or above it are flagged illegal.
REQ-003 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-high reset.
REQ-005 Port in_instr, input, 16, fetched instruction word.
REQ-006 Port in_valid, input, 1, in_instr is valid this cycle.
REQ-007 Port in_ready, output, 1, stage accepts a word this cycle.
REQ-008 Port flush, input, 1, synchronous discard of all held words.
REQ-009 Port out_valid, output, 1, decoded fields are valid.
REQ-010 Port out_ready, input, 1, downstream consumes this cycle.
REQ-011 Port out_opcode, output, 4, instr[15:12].
REQ-012 Port out_rd, output, 3, instr[11:9].
REQ-013 Port out_rs, output, 3, instr[8:6].
REQ-014 Port out_rt, output, 3, instr[2:0].
REQ-015 Port out_imm_sel, output, 1, instr[5]; 1 selects the immediate operand.
REQ-016 Port out_imm5, output, 5, instr[4:0], raw; it feeds the existing 5-to-16 sign extender unchanged.
REQ-017 Port out_illegal, output, 1, opcode >= OPC_ILLEGAL_MIN.
REQ-018 Port decode_count, output, 16, count of words handed downstream.

Function
REQ-019 The stage SHALL be a 2-entry skid buffer with FSM states EMPTY, ONE and TWO.
REQ-020 Accept occurs when in_valid && in_ready; hand-off occurs when out_valid && out_ready.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO; it is registered and does not depend combinationally on out_ready.
REQ-022 out_valid SHALL be 1 in ONE and TWO.
REQ-023 Outputs SHALL always reflect the oldest held word, with zero-cycle decode from the registered word.
REQ-024 Transitions:
- EMPTY + accept -> ONE.
- ONE + accept without hand-off -> TWO.
- ONE + hand-off without accept -> EMPTY.
- ONE + accept and hand-off -> ONE, holding the new word.
- TWO + hand-off -> ONE; the skid word becomes the head.
REQ-025 Latency SHALL be 1 cycle from accept to out_valid when the stage is EMPTY.
REQ-026 Words SHALL leave in acceptance order, with no loss and no duplication.
REQ-027 While out_valid=1 and out_ready=0, all out_* fields SHALL hold stable.
REQ-028 flush SHALL force EMPTY on the next edge and override any simultaneous accept or hand-off.
REQ-029 A hand-off in the flush cycle SHALL still count, but the accepted word is dropped.
REQ-030 decode_count SHALL increment by 1 per hand-off and wrap from 16'hFFFF to 16'h0000; flush does not clear it.
REQ-031 out_illegal SHALL be purely informational; illegal words pass through unchanged.

Reset
REQ-032 Asserting reset SHALL immediately force:
- state = EMPTY;
- out_valid = 0, in_ready = 0;
- all out_* fields = 0;
- decode_count = 0.
REQ-033 in_ready SHALL rise on the first clk edge after reset deasserts.
REQ-034 Reset mid-operation SHALL discard held words with no hand-off counted.

Structure
REQ-035 A shared package SHALL hold the opcode field positions, OPC_ILLEGAL_MIN and the state encoding (EMPTY=0, ONE=1, TWO=2).
REQ-036 One combinational sub-module, instr_fields, SHALL split a 16-bit word into the decoded fields and the illegal flag; it is instantiated on the head register.

Verification
REQ-037 Reset, then in_instr=16'h3A4A with in_valid for 1 cycle and out_ready=1 -> next cycle out_valid=1, opcode=3, rd=5, rs=1, imm_sel=0, imm5=5'b01010, rt=2; decode_count=1 after hand-off.
REQ-038 Hold out_ready=0 and offer 3 words -> the first 2 are accepted, in_ready=0 in TWO, the third is held off; release out_ready -> the 3 words emerge in order.
REQ-039 Word 16'hC01A -> out_illegal=1, opcode=12, imm_sel=0, imm5=5'b11010, rt=2, and it is still handed off.
REQ-040 Assert flush in TWO together with in_valid -> EMPTY next cycle, out_valid=0, accepted word discarded.
REQ-041 Force decode_count to 16'hFFFF via 65535 hand-offs, then one more hand-off -> decode_count=16'h0000.
REQ-042 Assert reset asynchronously between edges while in ONE -> out_valid=0 immediately, with no hand-off counted.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared field positions, illegal-opcode bound and state encoding
// Purpose: constants and types shared by decode_stage and instr_fields.
package decode_stage_pkg;

  localparam int INSTR_W = 16;

  // Field positions inside the 16-bit instruction word
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 9;
  localparam int RS_HI   = 8;
  localparam int RS_LO   = 6;
  localparam int IMM_SEL = 5;
  localparam int IMM5_HI = 4;
  localparam int RT_HI   = 2;

  localparam logic [3:0] OPC_ILLEGAL_MIN = 4'd12;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/decode_stage_instr_fields.sv
// rtl/decode_stage_instr_fields.sv - combinational split of one instruction word into decoded fields
// Ports:
//   instr            16-bit instruction word
//   opcode/rd/rs/rt  register and opcode fields
//   imm_sel, imm5    immediate select and raw 5-bit immediate
//   illegal          opcode at or above OPC_ILLEGAL_MIN
module instr_fields
  import decode_stage_pkg::*;
#(
  parameter logic [3:0] OPC_ILLEGAL_MIN = decode_stage_pkg::OPC_ILLEGAL_MIN
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [2:0]         rd,
  output logic [2:0]         rs,
  output logic [2:0]         rt,
  output logic               imm_sel,
  output logic [4:0]         imm5,
  output logic               illegal
);

  always_comb begin
    opcode  = instr[OPC_HI:OPC_LO];
    rd      = instr[RD_HI:RD_LO];
    rs      = instr[RS_HI:RS_LO];
    imm_sel = instr[IMM_SEL];
    // rt overlaps the low immediate bits; the consumer picks via imm_sel
    imm5    = instr[IMM5_HI:0];
    rt      = instr[RT_HI:0];
    illegal = (instr[OPC_HI:OPC_LO] >= OPC_ILLEGAL_MIN);
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - 2-entry skid-buffered instruction decode stage
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_instr/in_valid/in_ready    upstream word handshake (in_ready registered)
//   flush               synchronous discard of all held words
//   out_valid/out_ready downstream handshake
//   out_*               decoded fields of the oldest held word
//   decode_count        wrapping count of words handed downstream
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int         IW              = 16,
  parameter logic [3:0] OPC_ILLEGAL_MIN = decode_stage_pkg::OPC_ILLEGAL_MIN
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] in_instr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_opcode,
  output logic [2:0]    out_rd,
  output logic [2:0]    out_rs,
  output logic [2:0]    out_rt,
  output logic          out_imm_sel,
  output logic [4:0]    out_imm5,
  output logic          out_illegal,
  output logic [15:0]   decode_count
);

  state_e        state_q, state_d;
  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] skid_q, skid_d;
  logic          in_ready_q, in_ready_d;
  logic [15:0]   count_q, count_d;
  logic          accept;
  logic          handoff;

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != ST_EMPTY);
  assign accept       = in_valid && in_ready_q;
  assign handoff      = out_valid && out_ready;
  assign decode_count = count_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d  = in_instr;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({accept, handoff})
          2'b10: begin
            skid_d  = in_instr;
            state_d = ST_TWO;
          end
          2'b01: state_d = ST_EMPTY;
          2'b11: head_d  = in_instr;
          default: state_d = ST_ONE;
        endcase
      end
      ST_TWO: begin
        // in_ready is low here, so only a hand-off can move the state
        if (handoff) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush wins over accept and hand-off for the held words; the
    // hand-off itself still counts below.
    if (flush) begin
      state_d = ST_EMPTY;
    end

    // Registered ready: derived from the next state, never from out_ready
    in_ready_d = (state_d != ST_TWO);
    count_d    = count_q + {15'd0, handoff};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      count_q    <= count_d;
    end
  end

  // Zero-cycle decode straight off the head register; head_q is cleared
  // by reset so every out_* field reads zero while reset is asserted.
  instr_fields #(
    .OPC_ILLEGAL_MIN(OPC_ILLEGAL_MIN)
  ) u_fields (
    .instr   (head_q),
    .opcode  (out_opcode),
    .rd      (out_rd),
    .rs      (out_rs),
    .rt      (out_rt),
    .imm_sel (out_imm_sel),
    .imm5    (out_imm5),
    .illegal (out_illegal)
  );

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard testbench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rd;
  logic [2:0]  out_rs;
  logic [2:0]  out_rt;
  logic        out_imm_sel;
  logic [4:0]  out_imm5;
  logic        out_illegal;
  logic [15:0] decode_count;

  decode_stage #(.IW(16), .OPC_ILLEGAL_MIN(4'd12)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_instr     (in_instr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_rd       (out_rd),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_imm_sel  (out_imm_sel),
    .out_imm5     (out_imm5),
    .out_illegal  (out_illegal),
    .decode_count (decode_count)
  );

  always #10 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mdl_cnt  = 16'd0;
  logic        mon_en   = 1'b0;
  logic        last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the field definitions using plain arithmetic
  function automatic logic [19:0] model_fields(input logic [15:0] w);
    int v;
    int opc;
    v   = int'(w);
    opc = v / 4096;
    return {4'(opc), 3'((v / 512) % 8), 3'((v / 64) % 8), 3'(v % 8),
            1'((v / 32) % 2), 5'(v % 32), (opc >= 12)};
  endfunction

  function automatic logic [19:0] dut_fields();
    return {out_opcode, out_rd, out_rs, out_rt, out_imm_sel, out_imm5, out_illegal};
  endfunction

  // Inputs change at negedge+2; each call sets up the next rising edge.
  task automatic drive(input logic v, input logic [15:0] w, input logic ordy, input logic fl);
    @(negedge clk);
    #2;
    in_valid  = v;
    in_instr  = w;
    out_ready = ordy;
    flush     = fl;
    last_acc  = v && in_ready && !fl;
    if (last_acc) exp_q.push_back(w);
  endtask

  // Monitor: checks at negedge+1, retires hand-offs/flushes at negedge+3
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        chk("decode_count", 32'(decode_count), 32'(mdl_cnt));
        if (out_valid && exp_q.size() != 0)
          chk("fields", 32'(dut_fields()), 32'(model_fields(exp_q[0])));
      end
      #2;
      if (mon_en) begin
        if (out_valid && out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          mdl_cnt = mdl_cnt + 16'd1;
        end
        if (flush) exp_q.delete();
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c0;
    reset = 1'b1; in_instr = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #5;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_fields", 32'(dut_fields()), 32'd0);
    chk("rst_count", 32'(decode_count), 32'd0);
    #20 reset = 1'b0;
    #1 chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 chk("in_ready_after_edge", 32'(in_ready), 32'd1);
    mon_en = 1'b1;

    // Single word decode and hand-off
    drive(1'b1, 16'h3A4A, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("w3A4A_valid", 32'(out_valid), 32'd1);
    chk("w3A4A_fields", 32'(dut_fields()), 32'({4'd3, 3'd5, 3'd1, 3'd2, 1'b0, 5'b01010, 1'b0}));
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("w3A4A_count", 32'(decode_count), 32'd1);

    // Backpressure: two accepted, third held off, then in-order drain
    c0 = mdl_cnt;
    drive(1'b1, 16'h1111, 1'b0, 1'b0);
    drive(1'b1, 16'h2222, 1'b0, 1'b0);
    drive(1'b1, 16'h3333, 1'b0, 1'b0);
    chk("two_in_ready", 32'(in_ready), 32'd0);
    chk("third_held_off", 32'(last_acc), 32'd0);
    last_acc = 1'b0;
    for (int i = 0; i < 8 && !last_acc; i++) drive(1'b1, 16'h3333, 1'b1, 1'b0);
    chk("third_accepted", 32'(last_acc), 32'd1);
    for (int i = 0; i < 4; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("three_drained", 32'(decode_count), 32'(c0 + 16'd3));

    // Illegal opcode still passes through
    drive(1'b1, 16'hC01A, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("illegal_fields", 32'(dut_fields()), 32'({4'd12, 3'd0, 3'd0, 3'd2, 1'b0, 5'b11010, 1'b1}));
    c0 = decode_count;
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("illegal_handed_off", 32'(decode_count), 32'(c0 + 16'd1));

    // Flush in TWO with in_valid
    drive(1'b1, 16'hA001, 1'b0, 1'b0);
    drive(1'b1, 16'hA002, 1'b0, 1'b0);
    drive(1'b1, 16'hA003, 1'b0, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("flush_two_valid", 32'(out_valid), 32'd0);
    chk("flush_two_ready", 32'(in_ready), 32'd1);

    // Flush in ONE with a simultaneous hand-off: counted, new word dropped
    drive(1'b1, 16'hB001, 1'b0, 1'b0);
    c0 = decode_count;
    drive(1'b1, 16'hB002, 1'b1, 1'b1);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("flush_handoff_count", 32'(decode_count), 32'(c0 + 16'd1));
    chk("flush_drop_valid", 32'(out_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0);
    for (int i = 0; i < 4; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0);

    // Asynchronous reset while in ONE
    drive(1'b1, 16'h5A5A, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd0);
    chk("async_rst_fields", 32'(dut_fields()), 32'd0);
    chk("async_rst_count", 32'(decode_count), 32'd0);
    exp_q.delete();
    mdl_cnt = 16'd0;
    #2 reset = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_ready", 32'(in_ready), 32'd1);
    mon_en = 1'b1;

    // 65535 hand-offs, then one more to wrap
    for (int i = 0; i < 65535; i++) drive(1'b1, 16'($urandom), 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("count_ffff", 32'(decode_count), 32'h0000FFFF);
    drive(1'b1, 16'h7123, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("count_wrap", 32'(decode_count), 32'h00000000);

    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
